systolic_job_scheduler: RTL and testbench
=========================================

Name: systolic_job_scheduler

Overview:
- Queues matrix-multiply jobs (A/B/C base addresses plus dimension n) from a host-side requester.
- Sequences them one at a time into the systolic controller: drives its address/dimension inputs, pulses its start, then waits for completion.
- Sits between the host/test interface and the systolic controller inside the systolic top level.
- Validates dimensions, detects hung jobs, and reports completion and errors.

Parameters:
- N, 4, array dimension; largest legal job n.
- DEPTH, 4, job FIFO entries (power of 2, ≥2).
- START_TIMEOUT, 16, cycles allowed in WAIT_START for sa_busy to rise.
- RUN_TIMEOUT, 4096, cycles allowed in RUN for sa_done.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- job_valid  in  1  host offers a job.
- job_ready  out  1  FIFO can accept; push when job_valid && job_ready.
- job_addr_a, job_addr_b, job_addr_c  in  12 each  job base addresses.
- job_n  in  4  job dimension.
- sa_addr_a, sa_addr_b, sa_addr_c  out  12 each  addresses to controller.
- sa_n  out  4  dimension to controller.
- sa_new_data  out  1  one-cycle start pulse to controller.
- sa_busy  in  1  controller is executing.
- sa_done  in  1  one-cycle completion pulse from controller.
- busy  out  1  scheduler not in IDLE, or FIFO non-empty.
- pending  out  $clog2(DEPTH)+1  FIFO occupancy.
- done_pulse  out  1  one cycle per retired job.
- jobs_done  out  16  retired-job count; wraps at 0xFFFF→0.
- err_bad_n  out  1  sticky: job with n==0 or n>N was dropped.
- err_timeout  out  1  sticky: start or run timeout occurred.
- err_clr  in  1  synchronous clear of both sticky errors.
- last_job_cycles  out  32  see Optional Feature.

Behaviour:
- Reset (rst=0, async), all registered outputs and state cleared:
  - FIFO empty, job_ready=1, pending=0.
  - sa_* outputs=0, sa_new_data=0.
  - done_pulse=0, jobs_done=0, both errors=0, last_job_cycles=0, state=IDLE.
  - Reset mid-job silently drops in-flight and queued jobs; no done_pulse.
- FIFO:
  - job_ready = !full; no bypass, so a full FIFO with a same-cycle pop still shows ready=0.
  - A push and a pop in the same cycle leaves pending unchanged.
  - Read/write pointers wrap modulo DEPTH.
- FSM states: IDLE, CHECK, LAUNCH, WAIT_START, RUN, RETIRE.
  - IDLE: if FIFO non-empty, pop the head into the job register → CHECK.
  - CHECK (1 cycle):
    - if n==0 or n>N: set err_bad_n, do not launch, → IDLE.
    - else load sa_addr_*/sa_n from the job register → LAUNCH.
  - LAUNCH (1 cycle): sa_new_data=1 → WAIT_START. sa_addr_*/sa_n stay stable from CHECK until the next CHECK loads a new job.
  - WAIT_START:
    - sa_busy=1 → RUN.
    - START_TIMEOUT cycles elapsed → set err_timeout, → IDLE.
    - An sa_done seen here counts as completion → RETIRE (covers degenerate fast jobs).
  - RUN:
    - sa_done=1 → RETIRE.
    - RUN_TIMEOUT cycles without sa_done → set err_timeout, → IDLE; the job is dropped, jobs_done is not incremented.
  - RETIRE (1 cycle): done_pulse=1, jobs_done+1 → IDLE.
- Latency:
  - Push into an empty FIFO while IDLE → sa_new_data high exactly 4 cycles later (push edge → IDLE pop → CHECK → LAUNCH).
  - Back-to-back jobs: minimum 4 cycles from RETIRE to the next sa_new_data.
- sa_done outside WAIT_START/RUN is ignored.
- err_clr: clears both sticky errors. If a new error sets in the same cycle, set wins.
- Timeout counters are 32-bit and reset on every state entry.

Optional Feature:
- Macro: SYSTOLIC_PERF_CAPTURE_EN.
- Defined:
  - A 32-bit counter counts cycles from LAUNCH (inclusive) to RETIRE (exclusive).
  - On entering RETIRE it is latched into last_job_cycles; the value holds until the next retire.
  - Timed-out jobs do not update it.
- Undefined: last_job_cycles is tied to 0 and no counter is synthesized.

Test Plan:
- Single job: push A=0x000, B=0x010, C=0x020, n=4 into idle.
  - sa_new_data pulses 1 cycle, 4 cycles after the push, with sa_addr_*/sa_n = those values.
  - Drive sa_busy 2 cycles later, sa_done 30 cycles later → done_pulse once, jobs_done=1; with the macro, last_job_cycles=33.
- Fill/backpressure: push 5 jobs with sa_busy/sa_done held low.
  - Job 1 issues; jobs 2-5 fill the FIFO, so pending=4 and job_ready=0; a 6th offer is not accepted.
  - Completing jobs issues them in push order.
- Bad n: push n=0, then n=5 (N=4), then n=2.
  - err_bad_n=1, no sa_new_data for the first two; n=2 launches.
  - err_clr → err_bad_n=0.
- Start timeout: push a valid job, keep sa_busy=0.
  - After 16 cycles in WAIT_START: err_timeout=1, state IDLE, jobs_done unchanged, next queued job launches.
- Run timeout: set RUN_TIMEOUT=64, raise sa_busy, never pulse sa_done → err_timeout=1 after 64 RUN cycles, no done_pulse.
- Reset mid-RUN with 2 jobs queued: assert rst=0 asynchronously.
  - Outputs clear immediately: pending=0, sa_new_data=0, busy=0, jobs_done=0.
  - After release, no stale job launches.

Source files
------------

// File: rtl/systolic_job_scheduler.sv
// rtl/systolic_job_scheduler.sv - job FIFO and launch sequencer in front of the systolic controller
// Optional per-job cycle capture is enabled by defining SYSTOLIC_PERF_CAPTURE_EN.
module systolic_job_scheduler #(
  parameter int N             = 4,
  parameter int DEPTH         = 4,
  parameter int START_TIMEOUT = 16,
  parameter int RUN_TIMEOUT   = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [11:0]            job_addr_a,
  input  logic [11:0]            job_addr_b,
  input  logic [11:0]            job_addr_c,
  input  logic [3:0]             job_n,
  output logic [11:0]            sa_addr_a,
  output logic [11:0]            sa_addr_b,
  output logic [11:0]            sa_addr_c,
  output logic [3:0]             sa_n,
  output logic                   sa_new_data,
  input  logic                   sa_busy,
  input  logic                   sa_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   done_pulse,
  output logic [15:0]            jobs_done,
  output logic                   err_bad_n,
  output logic                   err_timeout,
  input  logic                   err_clr,
  output logic [31:0]            last_job_cycles
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT   = DEPTH[AW:0];
  localparam logic [3:0]  N_MAX      = 4'(N);
  localparam logic [31:0] START_LAST = 32'(START_TIMEOUT - 1);
  localparam logic [31:0] RUN_LAST   = 32'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LAUNCH, S_WAIT_START, S_RUN, S_RETIRE
  } state_t;

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
    logic [3:0]  n;
  } job_t;

  job_t          mem_q [DEPTH];
  job_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  job_t          job_q, job_d;
  job_t          sa_q, sa_d;
  logic          new_data_q, new_data_d;
  logic          done_pulse_q, done_pulse_d;
  logic [15:0]   jobs_done_q, jobs_done_d;
  logic          err_bad_n_q, err_bad_n_d;
  logic          err_timeout_q, err_timeout_d;
  logic [31:0]   timer_q, timer_d;
  logic          push, pop;

  assign job_ready = (count_q != FULL_CNT);
  assign push      = job_valid && job_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  // FIFO bookkeeping: write on an accepted offer, read when the idle FSM takes the head
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {job_addr_a, job_addr_b, job_addr_c, job_n};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Job sequencing: validate, launch, wait for the controller, retire or time out
  always_comb begin
    state_d       = state_q;
    job_d         = job_q;
    sa_d          = sa_q;
    new_data_d    = 1'b0;
    done_pulse_d  = 1'b0;
    jobs_done_d   = jobs_done_q;
    err_bad_n_d   = err_bad_n_q & ~err_clr;
    err_timeout_d = err_timeout_q & ~err_clr;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          job_d   = mem_q[rd_ptr_q];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (job_q.n == 4'd0 || job_q.n > N_MAX) begin
          err_bad_n_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          sa_d    = job_q;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        new_data_d = 1'b1;
        state_d    = S_WAIT_START;
      end
      S_WAIT_START: begin
        // A controller that finishes before busy is ever seen still retires the job
        if (sa_done) begin
          state_d = S_RETIRE;
        end else if (sa_busy) begin
          state_d = S_RUN;
        end else if (timer_q == START_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_RUN: begin
        if (sa_done) begin
          state_d = S_RETIRE;
        end else if (timer_q == RUN_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_RETIRE: begin
        done_pulse_d = 1'b1;
        jobs_done_d  = jobs_done_q + 16'd1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    timer_d = (state_d != state_q) ? 32'd0 : timer_q + 32'd1;
  end

  // State, FIFO and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      job_q         <= '0;
      sa_q          <= '0;
      new_data_q    <= 1'b0;
      done_pulse_q  <= 1'b0;
      jobs_done_q   <= '0;
      err_bad_n_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      job_q         <= job_d;
      sa_q          <= sa_d;
      new_data_q    <= new_data_d;
      done_pulse_q  <= done_pulse_d;
      jobs_done_q   <= jobs_done_d;
      err_bad_n_q   <= err_bad_n_d;
      err_timeout_q <= err_timeout_d;
      timer_q       <= timer_d;
    end
  end

  assign sa_addr_a   = sa_q.a;
  assign sa_addr_b   = sa_q.b;
  assign sa_addr_c   = sa_q.c;
  assign sa_n        = sa_q.n;
  assign sa_new_data = new_data_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign pending     = count_q;
  assign done_pulse  = done_pulse_q;
  assign jobs_done   = jobs_done_q;
  assign err_bad_n   = err_bad_n_q;
  assign err_timeout = err_timeout_q;

`ifdef SYSTOLIC_PERF_CAPTURE_EN
  logic [31:0] perf_q, perf_d, last_cycles_q, last_cycles_d;

  // Count LAUNCH through the cycle before RETIRE; latch only when a job retires
  always_comb begin
    perf_d        = perf_q;
    last_cycles_d = last_cycles_q;
    if (state_q == S_CHECK) begin
      perf_d = 32'd0;
    end else if (state_q == S_LAUNCH || state_q == S_WAIT_START || state_q == S_RUN) begin
      perf_d = perf_q + 32'd1;
    end
    if (state_d == S_RETIRE && state_q != S_RETIRE) begin
      last_cycles_d = perf_q + 32'd1;
    end
  end

  // Performance capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q        <= '0;
      last_cycles_q <= '0;
    end else begin
      perf_q        <= perf_d;
      last_cycles_q <= last_cycles_d;
    end
  end

  assign last_job_cycles = last_cycles_q;
`else
  assign last_job_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// tb/tb_systolic_job_scheduler.sv - scoreboard bench for systolic_job_scheduler
module tb_systolic_job_scheduler;

  localparam int DEPTH = 4;
`ifdef SYSTOLIC_PERF_CAPTURE_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
    logic [3:0]  n;
  } job_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [11:0] job_addr_a, job_addr_b, job_addr_c;
  logic [3:0]  job_n;
  logic [11:0] sa_addr_a, sa_addr_b, sa_addr_c;
  logic [3:0]  sa_n;
  logic        sa_new_data;
  logic        sa_busy;
  logic        sa_done;
  logic        busy;
  logic [$clog2(DEPTH):0] pending;
  logic        done_pulse;
  logic [15:0] jobs_done;
  logic        err_bad_n;
  logic        err_timeout;
  logic        err_clr;
  logic [31:0] last_job_cycles;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          launches = 0;
  int          dones = 0;
  logic [15:0] exp_jobs = 16'd0;
  job_t        exp_q[$];

  systolic_job_scheduler #(
    .N(4), .DEPTH(DEPTH), .START_TIMEOUT(16), .RUN_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_addr_a(job_addr_a), .job_addr_b(job_addr_b), .job_addr_c(job_addr_c), .job_n(job_n),
    .sa_addr_a(sa_addr_a), .sa_addr_b(sa_addr_b), .sa_addr_c(sa_addr_c), .sa_n(sa_n),
    .sa_new_data(sa_new_data), .sa_busy(sa_busy), .sa_done(sa_done),
    .busy(busy), .pending(pending), .done_pulse(done_pulse), .jobs_done(jobs_done),
    .err_bad_n(err_bad_n), .err_timeout(err_timeout), .err_clr(err_clr),
    .last_job_cycles(last_job_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every launch must match the oldest expected job
  initial begin
    job_t e;
    forever begin
      @(negedge clk);
      if (rst && sa_new_data) begin
        launches++;
        if (exp_q.size() == 0) begin
          check("launch_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("launch_job", 64'({sa_addr_a, sa_addr_b, sa_addr_c, sa_n}), 64'(e));
        end
      end
      if (rst && done_pulse) begin
        dones++;
        exp_jobs = exp_jobs + 16'd1;
        check("jobs_done_at_pulse", 64'(jobs_done), 64'(exp_jobs));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "bench time bound exceeded");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] c, input logic [3:0] n);
    job_t j;
    check("push_ready", 64'(job_ready), 64'd1);
    job_addr_a = a;
    job_addr_b = b;
    job_addr_c = c;
    job_n      = n;
    job_valid  = 1'b1;
    j = {a, b, c, n};
    if (n != 4'd0 && n <= 4'd4) exp_q.push_back(j);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_launch(output int s);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sa_new_data) begin
        found = 1;
        break;
      end
    end
    if (!found) check("launch_wait", 64'd0, 64'd1);
    s = cyc;
  endtask

  // Launch, then signal completion during the first WAIT_START cycle after the pulse
  task automatic run_job();
    int s;
    wait_launch(s);
    tick();
    sa_done = 1'b1;
    tick();
    sa_done = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    int k, s, l0;
    rst = 1'b0;
    job_valid = 1'b0;
    job_addr_a = '0; job_addr_b = '0; job_addr_c = '0; job_n = '0;
    sa_busy = 1'b0; sa_done = 1'b0; err_clr = 1'b0;
    tick(); tick();
    check("rst_job_ready", 64'(job_ready), 64'd1);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sa_outputs", 64'({sa_addr_a, sa_addr_b, sa_addr_c, sa_n, sa_new_data}), 64'd0);
    check("rst_status", 64'({done_pulse, jobs_done, err_bad_n, err_timeout}), 64'd0);
    check("rst_last_cycles", 64'(last_job_cycles), 64'd0);
    rst = 1'b1;
    tick();

    // sa_done while idle must be ignored
    sa_done = 1'b1;
    tick();
    sa_done = 1'b0;
    tick(); tick();
    check("idle_done_ignored", 64'(jobs_done), 64'd0);

    // Single job: 4-cycle launch latency, 33-cycle LAUNCH..RETIRE span
    k = cyc;
    push_job(12'h000, 12'h010, 12'h020, 4'd4);
    wait_launch(s);
    check("launch_latency", 64'(s - k), 64'd4);
    tick();
    check("new_data_one_cycle", 64'(sa_new_data), 64'd0);
    tick();
    sa_busy = 1'b1;
    repeat (29) tick();
    sa_done = 1'b1;
    tick();
    sa_done = 1'b0;
    sa_busy = 1'b0;
    tick();
    check("single_done_pulse", 64'(done_pulse), 64'd1);
    tick();
    check("single_done_pulse_once", 64'(done_pulse), 64'd0);
    check("single_jobs_done", 64'(jobs_done), 64'd1);
    check("single_last_cycles", 64'(last_job_cycles), PERF_ON ? 64'd33 : 64'd0);
    check("single_busy_clear", 64'(busy), 64'd0);

    // Fill and backpressure: first job issues, four more fill the FIFO
    for (int i = 1; i <= 5; i++)
      push_job(12'(256 + i), 12'(512 + i), 12'(768 + i), 4'(i % 4 + 1));
    check("fill_pending", 64'(pending), 64'd4);
    check("fill_ready_low", 64'(job_ready), 64'd0);
    job_addr_a = 12'hEEE; job_addr_b = 12'hEEE; job_addr_c = 12'hEEE; job_n = 4'd3;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    check("sixth_rejected", 64'(pending), 64'd4);
    sa_done = 1'b1;
    tick();
    sa_done = 1'b0;
    repeat (4) run_job();
    tick(); tick();
    check("fill_jobs_done", 64'(jobs_done), 64'd6);
    check("fill_drained", 64'(exp_q.size()), 64'd0);
    check("fill_pending_empty", 64'(pending), 64'd0);

    // Bad n: n=0 and n=5 dropped, n=2 launches
    l0 = launches;
    push_job(12'h400, 12'h401, 12'h402, 4'd0);
    push_job(12'h410, 12'h411, 12'h412, 4'd5);
    push_job(12'h420, 12'h421, 12'h422, 4'd2);
    run_job();
    tick(); tick();
    check("badn_single_launch", 64'(launches - l0), 64'd1);
    check("badn_flag", 64'(err_bad_n), 64'd1);
    check("badn_no_timeout", 64'(err_timeout), 64'd0);
    clear_errors();
    check("badn_cleared", 64'(err_bad_n), 64'd0);

    // Start timeout: 16 WAIT_START cycles, then the queued job launches
    push_job(12'h500, 12'h501, 12'h502, 4'd3);
    push_job(12'h510, 12'h511, 12'h512, 4'd1);
    wait_launch(s);
    repeat (15) tick();
    check("start_tmo_not_yet", 64'(err_timeout), 64'd0);
    tick();
    check("start_tmo_flag", 64'(err_timeout), 64'd1);
    check("start_tmo_jobs_done", 64'(jobs_done), 64'd7);
    run_job();
    tick(); tick();
    check("after_tmo_jobs_done", 64'(jobs_done), 64'd8);
    clear_errors();
    check("tmo_cleared", 64'(err_timeout), 64'd0);

    // Run timeout: 64 RUN cycles without sa_done drops the job
    push_job(12'h600, 12'h601, 12'h602, 4'd4);
    wait_launch(s);
    tick();
    tick();
    sa_busy = 1'b1;
    repeat (64) tick();
    check("run_tmo_not_yet", 64'(err_timeout), 64'd0);
    tick();
    check("run_tmo_flag", 64'(err_timeout), 64'd1);
    sa_busy = 1'b0;
    tick(); tick();
    check("run_tmo_jobs_done", 64'(jobs_done), 64'd8);
    check("run_tmo_last_cycles", 64'(last_job_cycles), PERF_ON ? 64'd3 : 64'd0);
    check("run_tmo_idle", 64'(busy), 64'd0);
    check("dones_total", 64'(dones), 64'd8);

    // Reset mid-RUN with two jobs queued
    push_job(12'h700, 12'h701, 12'h702, 4'd2);
    push_job(12'h710, 12'h711, 12'h712, 4'd2);
    push_job(12'h720, 12'h721, 12'h722, 4'd2);
    wait_launch(s);
    tick();
    tick();
    sa_busy = 1'b1;
    tick();
    check("pre_rst_pending", 64'(pending), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_pending", 64'(pending), 64'd0);
    check("async_rst_outputs", 64'({sa_new_data, busy, done_pulse, err_timeout}), 64'd0);
    check("async_rst_jobs_done", 64'(jobs_done), 64'd0);
    check("async_rst_sa_addr", 64'({sa_addr_a, sa_n}), 64'd0);
    exp_q.delete();
    exp_jobs = 16'd0;
    sa_busy = 1'b0;
    l0 = launches;
    tick(); tick();
    rst = 1'b1;
    repeat (20) tick();
    check("no_stale_launch", 64'(launches - l0), 64'd0);
    check("post_rst_idle", 64'({busy, job_ready}), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
